// File: rtl/seq_addsub_if.sv
// seq_addsub_if: start/busy/done handshake and operand/result bus for seq_addsub
// master drives start, sub, a and b and observes the status and results.
// slave is the arithmetic unit.
interface seq_addsub_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   modport master (
      output start, sub, a, b,
      input  busy, done, result, carry_out, overflow, zero
   );
   modport slave (
      input  start, sub, a, b,
      output busy, done, result, carry_out, overflow, zero
   );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial add/subtract, DIGIT bits per cycle, with carry/overflow/zero flags
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - slave side of seq_addsub_if:
//           start/sub/a/b sampled when idle;
//           busy during the N run cycles;
//           done pulses for one cycle when result and flags are valid.
module seq_addsub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input logic         clk,
   input logic         reset,
   seq_addsub_if.slave bus
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("seq_addsub: DIGIT must divide WIDTH");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, res, res_next;
   logic             c, co, ov, z;
   logic [DIGIT:0]   s;
   logic             c_msb;
   always_comb begin
      s = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
      // carry into the top bit of the current digit; only meaningful on the last digit
      c_msb = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ s[DIGIT-1];
      // new digit enters at the top so the first (least significant) digit ends at bit 0
      res_next = (res >> DIGIT) | (WIDTH'(s[DIGIT-1:0]) << (WIDTH - DIGIT));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         a_sr  <= '0;
         b_sr  <= '0;
         res   <= '0;
         c     <= 1'b0;
         co    <= 1'b0;
         ov    <= 1'b0;
         z     <= 1'b0;
      end else if (bus.start && state != RUN) begin
         // subtract is a + ~b + 1: invert b here, the +1 is the initial carry
         a_sr  <= bus.a;
         b_sr  <= bus.b ^ {WIDTH{bus.sub}};
         c     <= bus.sub;
         cnt   <= '0;
         state <= RUN;
      end else if (state == RUN) begin
         a_sr <= a_sr >> DIGIT;
         b_sr <= b_sr >> DIGIT;
         res  <= res_next;
         c    <= s[DIGIT];
         cnt  <= cnt + CW'(1);
         if (cnt == LAST) begin
            co    <= s[DIGIT];
            ov    <= c_msb ^ s[DIGIT];
            z     <= res_next == '0;
            state <= DONE;
         end
      end else if (state == DONE) begin
         state <= IDLE;
      end
   end
   assign bus.busy      = state == RUN;
   assign bus.done      = state == DONE;
   assign bus.result    = res;
   assign bus.carry_out = co;
   assign bus.overflow  = ov;
   assign bus.zero      = z;
endmodule
